// File: rtl/match_ctrl.sv
// Match sequencer for the two-player game: serve countdown, rally,
// point hold, pause and match-over handling around the physics engine.
module match_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 90,
    parameter int POINT_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       phys_game_over,
    input  logic [1:0] phys_winner,
    output logic       phys_en,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [2:0] state,
    output logic [7:0] countdown,
    output logic [1:0] match_winner
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        POINT  = 3'd3,
        PAUSED = 3'd4,
        OVER   = 3'd5
    } state_e;

    localparam logic [3:0] WIN = 4'(WIN_SCORE);
    localparam logic [7:0] SF  = 8'(SERVE_FRAMES);
    localparam logic [7:0] PF  = 8'(POINT_FRAMES);

    state_e     state_q, state_d, saved_q, saved_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] s1_q, s1_d, s2_q, s2_d;
    logic [1:0] win_q, win_d;
    logic       armed_q, armed_d;
    logic       start_q, pause_q;
    logic       start_e, pause_e, valid_pt;

    assign start_e  = start_btn & ~start_q;
    assign pause_e  = pause_btn & ~pause_q;
    assign phys_en  = frame_tick & (state_q == PLAY);
    assign valid_pt = armed_q & phys_game_over &
                      (phys_winner == 2'd1 || phys_winner == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            saved_q <= IDLE;
            cnt_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            win_q   <= '0;
            armed_q <= 1'b0;
            start_q <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            win_q   <= win_d;
            armed_q <= armed_d;
            start_q <= start_btn;
            pause_q <= pause_btn;
        end
    end

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        cnt_d   = cnt_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        win_d   = win_q;
        armed_d = armed_q;
        unique case (state_q)
            IDLE, OVER: begin
                if (start_e) begin
                    s1_d    = '0;
                    s2_d    = '0;
                    win_d   = '0;
                    armed_d = 1'b0;
                    cnt_d   = SF;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (pause_e) begin
                    saved_d = SERVE;
                    state_d = PAUSED;
                end else if (frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = '0;
                        armed_d = 1'b0;
                        state_d = PLAY;
                    end
                end
            end
            PLAY: begin
                if (phys_en) armed_d = 1'b1;
                if (pause_e) begin
                    saved_d = PLAY;
                    state_d = PAUSED;
                end else if (valid_pt) begin
                    if (phys_winner == 2'd1 && s1_q != WIN) s1_d = s1_q + 4'd1;
                    if (phys_winner == 2'd2 && s2_q != WIN) s2_d = s2_q + 4'd1;
                    cnt_d   = PF;
                    state_d = POINT;
                end
            end
            POINT: begin
                if (pause_e) begin
                    saved_d = POINT;
                    state_d = PAUSED;
                end else if (frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        if (s1_q == WIN || s2_q == WIN) begin
                            win_d   = (s1_q == WIN) ? 2'd1 : 2'd2;
                            cnt_d   = '0;
                            state_d = OVER;
                        end else begin
                            cnt_d   = SF;
                            state_d = SERVE;
                        end
                    end
                end
            end
            PAUSED: begin
                // ticks are dropped here; only a pause edge resumes
                if (pause_e) state_d = saved_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state        = state_q;
    assign score_p1     = s1_q;
    assign score_p2     = s2_q;
    assign match_winner = win_q;
    assign countdown    = (state_q == SERVE || state_q == POINT) ? cnt_q : 8'd0;

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, points needed to win a match (range 1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 90, frame ticks of frozen countdown before each rally (range 1..255).
REQ-003 SHALL have parameter POINT_FRAMES, default 60, frame ticks of frozen hold after a point (range 1..255).
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port frame_tick  input  1  one-cycle 60 Hz pulse.
REQ-007 SHALL have port start_btn  input  1  debounced level; the rising edge is used.
REQ-008 SHALL have port pause_btn  input  1  debounced level; the rising edge is used.
REQ-009 SHALL have port phys_game_over  input  1  point-ended flag from the physics engine.
REQ-010 SHALL have port phys_winner  input  2  point winner from the physics engine: 1 = P1, 2 = P2; 0 and 3 are invalid.
REQ-011 SHALL have port phys_en  output  1  frame enable to the physics engine.
REQ-012 SHALL have port score_p1  output  4  P1 points.
REQ-013 SHALL have port score_p2  output  4  P2 points.
REQ-014 SHALL have port state  output  3  encoding IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSED=4, OVER=5.
REQ-015 SHALL have port countdown  output  8  frame ticks remaining in SERVE or POINT; 0 in all other states.
REQ-016 SHALL have port match_winner  output  2  0 = none, 1 = P1, 2 = P2.

Function
REQ-017 SHALL detect button edges using registered previous-level flops; an edge is the current level 1 with the previous level 0.
REQ-018 SHALL drive phys_en combinationally as frame_tick AND (state==PLAY); phys_en SHALL be 0 in every other state.
REQ-019 IDLE: on a start edge, SHALL clear both scores, clear match_winner, load countdown=SERVE_FRAMES and go to SERVE.
REQ-020 SERVE: SHALL decrement countdown on each frame_tick; on the tick that moves countdown from 1 to 0, SHALL go to PLAY in the next cycle.
REQ-021 On each entry to PLAY, SHALL clear an internal armed flag; the flag SHALL set on the first cycle in which phys_en=1.
REQ-022 PLAY: a point SHALL be accepted only when armed=1, phys_game_over=1 and phys_winner is 1 or 2; this discards the stale game_over flag held over from the previous point.
REQ-023 While armed=1, phys_game_over=1 with phys_winner of 0 or 3 SHALL be ignored and the block SHALL stay in PLAY.
REQ-024 On an accepted point, SHALL increment the winner's score by exactly 1, load countdown=POINT_FRAMES and go to POINT in the next cycle.
REQ-025 POINT: SHALL decrement countdown on each frame_tick; on reaching 0, if either score equals WIN_SCORE SHALL set match_winner to that side and go to OVER, otherwise SHALL load SERVE_FRAMES and go to SERVE.
REQ-026 Scores SHALL saturate at WIN_SCORE and SHALL never wrap.
REQ-027 A pause edge in SERVE, PLAY or POINT SHALL save the current state and go to PAUSED, freezing countdown, scores and armed.
REQ-028 PAUSED: a pause edge SHALL return to the saved state with countdown unchanged.
REQ-029 PAUSED: frame_tick SHALL be ignored.
REQ-030 OVER: SHALL hold scores and match_winner; a start edge SHALL behave exactly as in IDLE (REQ-019).
REQ-031 If a start edge and a pause edge occur in the same cycle, start SHALL take priority in IDLE and OVER, and pause SHALL take priority in all other states; start SHALL be ignored in SERVE, PLAY, POINT and PAUSED.
REQ-032 If frame_tick and a pause edge occur in the same cycle in SERVE or POINT, pause SHALL win and the tick SHALL be dropped.
REQ-033 If frame_tick and a pause edge occur in the same cycle in PLAY, phys_en SHALL still pulse in that cycle (the combinational path) and the block SHALL enter PAUSED in the next cycle.

Reset
REQ-034 Asserting rst_n low SHALL immediately force state=IDLE, score_p1=score_p2=0, countdown=0, match_winner=0, phys_en=0, armed=0, saved state=IDLE and both button history flops to 0.
REQ-035 Reset asserted in mid-match SHALL discard all progress, with no residual pause or armed state after release.

Verification
REQ-036 Start edge in IDLE, then 90 ticks -> SERVE with countdown stepping 90..1, then PLAY; phys_en pulses only on ticks in PLAY.
REQ-037 Enter PLAY with phys_game_over=1 and phys_winner=2 held from cycle 0 -> no point before the first phys_en; after it -> score_p2=1 and state POINT with countdown=60.
REQ-038 Award 7 accepted P1 points -> after the 7th POINT hold, state=OVER, match_winner=1, score_p1=7; a further start edge -> IDLE-equivalent clear and SERVE.
REQ-039 Pause edge in SERVE at countdown=40, then 100 ticks, then pause edge -> countdown still 40 and state SERVE; pause edge coincident with a tick -> countdown not decremented.
REQ-040 phys_game_over=1 with phys_winner=0 or 3 while armed in PLAY -> scores unchanged, state stays PLAY.
REQ-041 rst_n pulsed low in POINT with scores 3:5 -> all outputs at reset values immediately; after release, a start edge begins a fresh match at 0:0.
